// File: rtl/decode_stage_hs.sv
// decode_stage_hs: handshaked instruction-decode stage.
//  - splits the 32-bit instruction, reads scalar and vector register banks
//    (write-first bypass from the writeback port), runs the control decoder
//  - per-register pending-write scoreboard with RAW interlock and flush
//  - valid/ready ID/EX output register
// Optional feature macro: DECODE_PERF_EN adds perf_issue / perf_stall counters.
module decode_stage_hs #(
    parameter int SW     = 24,
    parameter int LANES  = 6,
    parameter int NREGS  = 16,
    parameter int PC_W   = 24,
    parameter int PEND_W = 2,
    localparam int VW    = SW * LANES,
    localparam int BUS_W = 2 + 3 * VW + PC_W + 2 + 4 + 6 + 4 + 3 * (4 + SW) + SW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              wb_we_s,
    input  logic              wb_we_v,
    input  logic [3:0]        wb_rd,
    input  logic [SW-1:0]     wb_wd_s,
    input  logic [VW-1:0]     wb_wd_v,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BUS_W-1:0]  out_bus
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]       perf_issue,
    output logic [31:0]       perf_stall
`endif
);

    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_ZERO = PEND_W'(0);
    localparam logic [PEND_W-1:0] PEND_NEAR = PEND_MAX - PEND_ONE;

    localparam logic [3:0] OP_LOAD   = 4'hC;
    localparam logic [3:0] OP_STORE  = 4'hD;
    localparam logic [3:0] OP_BRANCH = 4'hE;
    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;

    // Register banks and scoreboard
    logic [SW-1:0]     bank_s [NREGS];
    logic [VW-1:0]     bank_v [NREGS];
    logic [PEND_W-1:0] pend_s [NREGS];
    logic [PEND_W-1:0] pend_v [NREGS];
    logic [NREGS-1:0]  inc_s, inc_v, dec_s, dec_v;

    // Destination of the instruction held in ID/EX
    logic [3:0] held_rc;
    logic       held_rw;
    logic       held_rwv;

    // Instruction fields
    logic [1:0]  op_type;
    logic [3:0]  op_code, rc, ra, rb;
    logic [17:0] imm;
    logic [SW-1:0] ext_imm;

    // Control decode
    logic [1:0] mode_sel;
    logic [3:0] alu_control;
    logic imm_src, branch_flag, mem_write, mem_to_reg, reg_write, reg_write_v;

    logic [SW-1:0] rd1, rd2, rd3;
    logic [VW-1:0] rdv1, rdv2, rdv3;
    logic [BUS_W-1:0] dec_bus;

    logic hazard, dest_full, adv, load, handoff;

    assign op_type = inst_i[31:30];
    assign op_code = inst_i[29:26];
    assign rc      = inst_i[25:22];
    assign ra      = inst_i[21:18];
    assign rb      = inst_i[17:14];
    assign imm     = inst_i[17:0];
    assign ext_imm = {{(SW-18){imm[17]}}, imm};

    // Scalar read port with write-first bypass from writeback.
    function automatic logic [SW-1:0] read_s(input logic [3:0] idx);
        return (wb_we_s && (wb_rd == idx)) ? wb_wd_s : bank_s[idx];
    endfunction

    // Vector read port with write-first bypass from writeback.
    function automatic logic [VW-1:0] read_v(input logic [3:0] idx);
        return (wb_we_v && (wb_rd == idx)) ? wb_wd_v : bank_v[idx];
    endfunction

    // RAW check for one used source in the given bank. A single outstanding
    // write that retires this very cycle is covered by the read bypass.
    function automatic logic src_hazard(input logic [3:0] s, input logic vec);
        logic [PEND_W-1:0] cnt;
        logic              wb_hit;
        logic              held_hit;
        cnt      = vec ? pend_v[s] : pend_s[s];
        wb_hit   = vec ? (wb_we_v && (wb_rd == s)) : (wb_we_s && (wb_rd == s));
        held_hit = out_valid && (held_rc == s) && (vec ? held_rwv : held_rw);
        return ((cnt != PEND_ZERO) && !((cnt == PEND_ONE) && wb_hit)) || held_hit;
    endfunction

    assign rd1  = read_s(ra);
    assign rd2  = read_s(rb);
    assign rd3  = read_s(rc);
    assign rdv1 = read_v(ra);
    assign rdv2 = read_v(rb);
    assign rdv3 = read_v(rc);

    // Control decoder: opType selects class, opCode the ALU op or memory/branch kind.
    always_comb begin
        mode_sel    = 2'b00;
        imm_src     = 1'b0;
        branch_flag = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        reg_write_v = 1'b0;
        alu_control = op_code;
        case (op_type)
            2'b00: reg_write = 1'b1;
            2'b01: begin
                imm_src = 1'b1;
                case (op_code)
                    OP_LOAD: begin
                        mem_to_reg  = 1'b1;
                        reg_write   = 1'b1;
                        alu_control = ALU_ADD;
                    end
                    OP_STORE: begin
                        mem_write   = 1'b1;
                        alu_control = ALU_ADD;
                    end
                    OP_BRANCH: begin
                        branch_flag = 1'b1;
                        alu_control = ALU_SUB;
                    end
                    default: reg_write = 1'b1;
                endcase
            end
            2'b10: begin
                mode_sel    = 2'b01;
                reg_write_v = 1'b1;
            end
            2'b11: begin
                mode_sel    = 2'b10;
                imm_src     = 1'b1;
                reg_write_v = 1'b1;
            end
            default: mode_sel = 2'b00;
        endcase
    end

    // Interlock: RAW on used sources plus destination-counter headroom. A
    // held instruction to the same destination will add one more pending
    // write on handoff, so one below saturation is already full in that case.
    always_comb begin
        dest_full = 1'b0;
        if (reg_write && ((pend_s[rc] == PEND_MAX) ||
            ((pend_s[rc] == PEND_NEAR) && out_valid && held_rw && (held_rc == rc)))) begin
            dest_full = 1'b1;
        end else if (reg_write_v && ((pend_v[rc] == PEND_MAX) ||
            ((pend_v[rc] == PEND_NEAR) && out_valid && held_rwv && (held_rc == rc)))) begin
            dest_full = 1'b1;
        end else begin
            dest_full = 1'b0;
        end
        hazard = src_hazard(ra, op_type[1])
               | (!imm_src && src_hazard(rb, op_type[1]))
               | ((mem_write || branch_flag) && src_hazard(rc, op_type[1]))
               | dest_full;
    end

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !hazard && !flush;
    assign load     = in_valid && in_ready;
    assign handoff  = out_valid && out_ready && !flush;

    assign dec_bus = {mode_sel, rdv1, rdv2, rdv3, pc_i, op_type, op_code,
                      imm_src, branch_flag, mem_write, mem_to_reg, reg_write, reg_write_v,
                      alu_control, ra, rd1, rb, rd2, rc, rd3, ext_imm};

    // Per-register increment (handoff of held destination) and decrement (writeback) strobes.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            inc_s[i] = handoff && held_rw  && (held_rc == 4'(i));
            inc_v[i] = handoff && held_rwv && (held_rc == 4'(i));
            dec_s[i] = wb_we_s && (wb_rd == 4'(i));
            dec_v[i] = wb_we_v && (wb_rd == 4'(i));
        end
    end

    // Register banks: independent scalar/vector writes from writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                bank_s[i] <= '0;
                bank_v[i] <= '0;
            end
        end else begin
            if (wb_we_s) begin
                bank_s[wb_rd] <= wb_wd_s;
            end
            if (wb_we_v) begin
                bank_v[wb_rd] <= wb_wd_v;
            end
        end
    end

    // Pending-write counters: saturate at max, ignore underflow, inc+dec cancels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                pend_s[i] <= PEND_ZERO;
                pend_v[i] <= PEND_ZERO;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (inc_s[i] && !dec_s[i] && (pend_s[i] != PEND_MAX)) begin
                    pend_s[i] <= pend_s[i] + PEND_ONE;
                end else if (dec_s[i] && !inc_s[i] && (pend_s[i] != PEND_ZERO)) begin
                    pend_s[i] <= pend_s[i] - PEND_ONE;
                end
                if (inc_v[i] && !dec_v[i] && (pend_v[i] != PEND_MAX)) begin
                    pend_v[i] <= pend_v[i] + PEND_ONE;
                end else if (dec_v[i] && !inc_v[i] && (pend_v[i] != PEND_ZERO)) begin
                    pend_v[i] <= pend_v[i] - PEND_ONE;
                end
            end
        end
    end

    // ID/EX register: flush wins, then load, then drain; stall holds everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_bus   <= '0;
            held_rc   <= 4'h0;
            held_rw   <= 1'b0;
            held_rwv  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_bus   <= dec_bus;
            held_rc   <= rc;
            held_rw   <= reg_write;
            held_rwv  <= reg_write_v;
        end else if (adv) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DECODE_PERF_EN
    // Issue and interlock-stall event counters, free-running with wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issue <= 32'h0000_0000;
            perf_stall <= 32'h0000_0000;
        end else begin
            if (load) begin
                perf_issue <= perf_issue + 32'h0000_0001;
            end
            if (in_valid && hazard) begin
                perf_stall <= perf_stall + 32'h0000_0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed testbench for decode_stage_hs at default parameters (582-bit bus).
module tb_decode_stage_hs;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  inst_i;
    logic [23:0]  pc_i;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic         wb_we_s;
    logic         wb_we_v;
    logic [3:0]   wb_rd;
    logic [23:0]  wb_wd_s;
    logic [143:0] wb_wd_v;
    logic         out_valid;
    logic         out_ready;
    logic [581:0] out_bus;
`ifdef DECODE_PERF_EN
    logic [31:0]  perf_issue;
    logic [31:0]  perf_stall;
`endif

    int checks = 0;
    int failures = 0;

    localparam logic [143:0] VVAL = 144'h0123456789ABCDEF_FEDCBA9876543210_55A5;

    decode_stage_hs dut (
        .clk       (clk),
        .rst       (rst),
        .inst_i    (inst_i),
        .pc_i      (pc_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .wb_we_s   (wb_we_s),
        .wb_we_v   (wb_we_v),
        .wb_rd     (wb_rd),
        .wb_wd_s   (wb_wd_s),
        .wb_wd_v   (wb_wd_v),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bus   (out_bus)
`ifdef DECODE_PERF_EN
        ,
        .perf_issue(perf_issue),
        .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [1:0] ot, input logic [3:0] oc,
                                       input logic [3:0] rc, input logic [3:0] ra,
                                       input logic [3:0] rb);
        return {ot, oc, rc, ra, rb, 14'h0000};
    endfunction

    function automatic logic [31:0] mk_imm(input logic [1:0] ot, input logic [3:0] oc,
                                           input logic [3:0] rc, input logic [3:0] ra,
                                           input logic [17:0] imm);
        return {ot, oc, rc, ra, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_scalar(input logic [3:0] rd, input logic [23:0] wd);
        wb_we_s = 1'b1; wb_rd = rd; wb_wd_s = wd;
        tick();
        wb_we_s = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; inst_i = 32'h0; pc_i = 24'h0; in_valid = 1'b0; flush = 1'b0;
        wb_we_s = 1'b0; wb_we_v = 1'b0; wb_rd = 4'h0; wb_wd_s = 24'h0; wb_wd_v = 144'h0;
        out_ready = 1'b1;
        tick(); tick();
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_bus !== 582'h0) begin failures++; $display("FAIL reset_bus: got nonzero expected 0"); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        // preload R1=0x0A, R2=0x14 (writebacks with pend=0 must leave counters at 0)
        wb_scalar(4'd1, 24'h00000A);
        wb_scalar(4'd2, 24'h000014);
    endtask

    task automatic test_raw_interlock();
        out_ready = 1'b1;
        inst_i = mk(2'b00, 4'h0, 4'd3, 4'd1, 4'd2); pc_i = 24'h000010; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_first_ready: got %b expected 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL raw_first_valid: got %b expected 1", out_valid); end
        checks++; if (out_bus[103:80] !== 24'h00000A) begin failures++; $display("FAIL raw_rd1: got %h expected 00000a", out_bus[103:80]); end
        checks++; if (out_bus[75:52] !== 24'h000014) begin failures++; $display("FAIL raw_rd2: got %h expected 000014", out_bus[75:52]); end
        inst_i = mk(2'b00, 4'h0, 4'd5, 4'd3, 4'd3); pc_i = 24'h000011;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_held_stall: got %b expected 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL raw_bubble: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_pend_stall1: got %b expected 0", in_ready); end
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_pend_stall2: got %b expected 0", in_ready); end
        wb_we_s = 1'b1; wb_rd = 4'd3; wb_wd_s = 24'h00ABCD;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_wb_release: got %b expected 1", in_ready); end
        tick();
        wb_we_s = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL raw_second_valid: got %b expected 1", out_valid); end
        checks++; if (out_bus[103:80] !== 24'h00ABCD) begin failures++; $display("FAIL raw_bypass_rd1: got %h expected 00abcd", out_bus[103:80]); end
        checks++; if (out_bus[75:52] !== 24'h00ABCD) begin failures++; $display("FAIL raw_bypass_rd2: got %h expected 00abcd", out_bus[75:52]); end
        tick();                      // R5 handed off
        wb_scalar(4'd5, 24'h000055);
    endtask

    task automatic test_stall();
        logic [581:0] exp_bus;
        exp_bus = {2'b00, 144'h0, 144'h0, 144'h0, 24'h000100, 2'b00, 4'h2, 6'b000010, 4'h2,
                   4'h1, 24'h00000A, 4'h2, 24'h000014, 4'h8, 24'h000000, 24'h008000};
        out_ready = 1'b0;
        inst_i = mk(2'b00, 4'h2, 4'd8, 4'd1, 4'd2); pc_i = 24'h000100; in_valid = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_load_valid: got %b expected 1", out_valid); end
        inst_i = mk(2'b00, 4'h1, 4'd9, 4'd1, 4'd2); pc_i = 24'h000104;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc%0d: got %b expected 0", c, in_ready); end
            checks++; if (out_bus !== exp_bus) begin failures++; $display("FAIL stall_bus cyc%0d: got %h expected %h", c, out_bus, exp_bus); end
            tick();
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_hold_valid: got %b expected 1", out_valid); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
        tick();                      // R9 instr loaded, R8 handed off once
        in_valid = 1'b0;
        tick();                      // R9 handed off
        inst_i = mk(2'b00, 4'h0, 4'd10, 4'd8, 4'd8);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_pend8: got %b expected 0", in_ready); end
        wb_we_s = 1'b1; wb_rd = 4'd8; wb_wd_s = 24'h000088;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_pend8_once: got %b expected 1", in_ready); end
        tick();
        wb_scalar(4'd9, 24'h000099);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        inst_i = mk(2'b00, 4'h0, 4'd11, 4'd1, 4'd2); in_valid = 1'b1;
        tick();
        inst_i = mk(2'b00, 4'h0, 4'd12, 4'd1, 4'd2); flush = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        inst_i = mk(2'b00, 4'h0, 4'd13, 4'd11, 4'd12);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_no_pend: got %b expected 1", in_ready); end
    endtask

    task automatic test_vector_bypass();
        out_ready = 1'b1;
        wb_we_v = 1'b1; wb_rd = 4'd7; wb_wd_v = VVAL;
        inst_i = mk(2'b10, 4'h0, 4'd2, 4'd7, 4'd7); in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL vec_ready: got %b expected 1", in_ready); end
        tick();
        wb_we_v = 1'b0; in_valid = 1'b0;
        checks++; if (out_bus[579:436] !== VVAL) begin failures++; $display("FAIL vec_rdv1: got %h expected %h", out_bus[579:436], VVAL); end
        checks++; if (out_bus[435:292] !== VVAL) begin failures++; $display("FAIL vec_rdv2: got %h expected %h", out_bus[435:292], VVAL); end
        checks++; if (out_bus[103:80] !== 24'h000000) begin failures++; $display("FAIL vec_scalar_r7: got %h expected 000000", out_bus[103:80]); end
        checks++; if (out_bus[581:580] !== 2'b01) begin failures++; $display("FAIL vec_mode: got %b expected 01", out_bus[581:580]); end
        tick();                      // V2 handed off
        inst_i = mk(2'b00, 4'h0, 4'd4, 4'd7, 4'd7); in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL vec_scalar_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_bus[103:80] !== 24'h000000) begin failures++; $display("FAIL vec_r7_stored: got %h expected 000000", out_bus[103:80]); end
        checks++; if (out_bus[579:436] !== VVAL) begin failures++; $display("FAIL vec_v7_stored: got %h expected %h", out_bus[579:436], VVAL); end
        tick();                      // R4 handed off
        wb_we_v = 1'b1; wb_we_s = 1'b1; wb_rd = 4'd2; wb_wd_v = 144'h0; wb_wd_s = 24'h0;
        tick();
        wb_we_v = 1'b0; wb_rd = 4'd4;
        tick();
        wb_we_s = 1'b0;
    endtask

    task automatic test_imm_extend();
        out_ready = 1'b1;
        inst_i = mk_imm(2'b01, 4'h0, 4'd4, 4'd1, 18'h20000); in_valid = 1'b1;
        tick();
        checks++; if (out_bus[23:0] !== 24'hFE0000) begin failures++; $display("FAIL imm_neg: got %h expected fe0000", out_bus[23:0]); end
        checks++; if (out_bus[117] !== 1'b1) begin failures++; $display("FAIL imm_src: got %b expected 1", out_bus[117]); end
        inst_i = mk_imm(2'b01, 4'h0, 4'd4, 4'd1, 18'h1FFFF);
        tick();
        in_valid = 1'b0;
        checks++; if (out_bus[23:0] !== 24'h01FFFF) begin failures++; $display("FAIL imm_pos: got %h expected 01ffff", out_bus[23:0]); end
        tick();
        wb_scalar(4'd4, 24'h0);
        wb_scalar(4'd4, 24'h0);
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        inst_i = mk(2'b00, 4'h0, 4'd14, 4'd1, 4'd2); in_valid = 1'b1;
        tick();                      // A loaded
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL sat_b_ready: got %b expected 1", in_ready); end
        tick();                      // B loaded, pend=1
        tick();                      // C loaded, pend=2
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL sat_near: got %b expected 0", in_ready); end
        tick();                      // C handed off, pend=3
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL sat_full: got %b expected 0", in_ready); end
        wb_we_s = 1'b1; wb_rd = 4'd14; wb_wd_s = 24'h0;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL sat_full_wb: got %b expected 0", in_ready); end
        tick();                      // pend=2
        wb_we_s = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL sat_room: got %b expected 1", in_ready); end
        in_valid = 1'b0;
        wb_scalar(4'd14, 24'h0);
        wb_scalar(4'd14, 24'h0);
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        inst_i = mk(2'b00, 4'h0, 4'd6, 4'd1, 4'd2); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid: got %b expected 0", out_valid); end
        tick();
        rst = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
        inst_i = mk(2'b00, 4'h0, 4'd6, 4'd1, 4'd3); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_bus[103:80] !== 24'h000000) begin failures++; $display("FAIL mid_rd1_cleared: got %h expected 000000", out_bus[103:80]); end
        checks++; if (out_bus[75:52] !== 24'h000000) begin failures++; $display("FAIL mid_rd2_cleared: got %h expected 000000", out_bus[75:52]); end
    endtask

    initial begin
        test_reset();
        test_raw_interlock();
        test_stall();
        test_flush();
        test_vector_bypass();
        test_imm_extend();
        test_saturation();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
